// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming 2-D convolution engine.
// Imported by the top module and its line-buffer sub-module.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Result width that can hold K*K full-scale unsigned products.
    function automatic int acc_width(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k);
    endfunction

    // Number of valid-mode output windows per frame.
    function automatic int n_out(input int img_w, input int img_h,
                                 input int k);
        return (img_h - k + 1) * (img_w - k + 1);
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row delay line: the output is the pixel accepted DEPTH
// shifts ago, i.e. the same column of the previous row.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Shift one position per accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// Streaming valid-mode 2-D convolution: raster pixels in, one result per
// window out, with a two-stage product/sum pipeline and backpressure.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int K      = 3,
    parameter int ACC_W  = acc_width(DATA_W, K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int NK    = K * K;
    localparam int PW    = 2 * DATA_W;
    localparam int N_OUT = n_out(IMG_W, IMG_H, K);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int WCW   = $clog2(NK + 1);
    localparam int OCW   = $clog2(N_OUT + 1);

    state_e            state_q;
    logic              busy_q, done_q;
    logic [WCW-1:0]    w_cnt_q;
    logic [DATA_W-1:0] w_q [NK];
    logic [CW-1:0]     c_q;
    logic [RW-1:0]     r_q;
    logic [OCW-1:0]    win_cnt_q;
    logic [DATA_W-1:0] win_q [NK];
    logic [DATA_W-1:0] win_d [NK];
    logic [DATA_W-1:0] tap [K];
    logic [DATA_W-1:0] lb_d [K-1];
    logic [DATA_W-1:0] lb_q [K-1];
    logic [PW-1:0]     prod_q [NK];
    logic              s1_valid_q, s1_last_q;
    logic [ACC_W-1:0]  sum_d;
    logic              out_valid_q, out_last_q;
    logic [ACC_W-1:0]  out_data_q;

    logic adv, fire, w_loaded, start_ok;
    logic col_end, row_end, last_px, complete, last_win;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_RUN) && adv;
    assign fire     = in_valid && in_ready;
    assign w_loaded = (int'(w_cnt_q) == NK);
    assign start_ok = (state_q == S_IDLE) && start && w_loaded;
    assign col_end  = (int'(c_q) == IMG_W - 1);
    assign row_end  = (int'(r_q) == IMG_H - 1);
    assign last_px  = col_end && row_end;
    assign complete = (int'(r_q) >= K - 1) && (int'(c_q) >= K - 1);
    assign last_win = (int'(win_cnt_q) == N_OUT - 1);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Frame control: idle until a start with a loaded kernel, then drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start_ok) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
                S_RUN: if (fire && last_px) state_q <= S_DRAIN;
                S_DRAIN: if (out_valid_q && out_ready && out_last_q) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Serial kernel load; newest weight enters at the top index.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_cnt_q <= '0;
            for (int k = 0; k < NK; k++) w_q[k] <= '0;
        end else if (state_q == S_IDLE && w_valid) begin
            for (int k = 0; k < NK - 1; k++) w_q[k] <= w_q[k+1];
            w_q[NK-1] <= w_data;
            if (!w_loaded) w_cnt_q <= w_cnt_q + WCW'(1);
        end
    end

    // Raster position and completed-window count for the current frame.
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            c_q       <= '0;
            r_q       <= '0;
            win_cnt_q <= '0;
        end else if (fire) begin
            c_q <= col_end ? '0 : c_q + CW'(1);
            if (col_end) r_q <= r_q + RW'(1);
            if (complete) win_cnt_q <= win_cnt_q + OCW'(1);
        end
    end

    genvar g;
    for (g = 0; g < K - 1; g++) begin : g_lb
        if (g == 0) begin : g_head
            assign lb_d[g] = in_data;
        end else begin : g_chain
            assign lb_d[g] = lb_q[g-1];
        end
        conv_line_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_lb (
            .clk   (clk),
            .reset (reset),
            .en_i  (fire),
            .d_i   (lb_d[g]),
            .q_o   (lb_q[g])
        );
        assign tap[K-2-g] = lb_q[g];
    end
    assign tap[K-1] = in_data;

    // Next window: shift columns left, new column from the row taps.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_d[i*K+j] = win_q[i*K+j+1];
            end
            win_d[i*K+K-1] = tap[i];
        end
    end

    // Window register follows accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
        end else if (fire) begin
            for (int k = 0; k < NK; k++) win_q[k] <= win_d[k];
        end
    end

    // Stage 1: products of the window being completed this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int k = 0; k < NK; k++) prod_q[k] <= '0;
        end else if (adv) begin
            s1_valid_q <= fire && complete;
            s1_last_q  <= fire && complete && last_win;
            for (int k = 0; k < NK; k++) begin
                prod_q[k] <= PW'(win_d[k]) * PW'(w_q[k]);
            end
        end
    end

    // Zero-extended sum of the stage-1 products.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NK; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
    end

    // Stage 2: result register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_last_q;
            out_data_q  <= sum_d;
        end
    end

endmodule
